// File: rtl/level_tracker.sv
// Pushbutton synchronizer/debouncer feeding a hit/miss scored level FSM.
// Lvl: 0 idle, 1..MAX_LVL-1 playing, MAX_LVL win.
module level_tracker #(
    parameter int DEB_CYCLES   = 50000,
    parameter int DEB_W        = 16,
    parameter int HITS_PER_LVL = 3,
    parameter int MISS_LIMIT   = 2,
    parameter int MAX_LVL      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       Tgt,
    output logic [2:0] Lvl,
    output logic       LvlUp,
    output logic       LvlDn
);

    localparam int HW = (HITS_PER_LVL > 1) ? $clog2(HITS_PER_LVL) : 1;
    localparam int MW = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HW-1:0]    HIT_LAST  = HW'(HITS_PER_LVL - 1);
    localparam logic [MW-1:0]    MISS_LAST = MW'(MISS_LIMIT - 1);
    localparam logic [2:0]       LVL_WIN   = 3'(MAX_LVL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2
    } state_t;

    logic             s1_q, s2_q;
    logic             deb_q, deb_prev_q;
    logic [DEB_W-1:0] cnt_q;
    logic             press;

    // Input conditioning: 2-flop synchronizer, then a counter that must see
    // DEB_CYCLES consecutive disagreeing samples before accepting the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= btn;
            s2_q       <= s1_q;
            deb_prev_q <= deb_q;
            if (s2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
                deb_q <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DEB_W'(1);
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    state_t        state_q, state_d;
    logic [2:0]    lvl_q, lvl_d;
    logic [HW-1:0] hits_q, hits_d;
    logic [MW-1:0] misses_q, misses_d;
    logic          up_q, up_d;
    logic          dn_q, dn_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lvl_q    <= 3'd0;
            hits_q   <= '0;
            misses_q <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        up_d     = 1'b0;
        dn_d     = 1'b0;
        case (state_q)
            IDLE: begin
                lvl_d = 3'd0;
                if (press) begin
                    state_d  = PLAY;
                    lvl_d    = 3'd1;
                    hits_d   = '0;
                    misses_d = '0;
                end
            end
            PLAY: begin
                if (press && Tgt) begin
                    misses_d = '0;
                    if (hits_q == HIT_LAST) begin
                        hits_d = '0;
                        lvl_d  = lvl_q + 3'd1;
                        up_d   = 1'b1;
                        if (lvl_q + 3'd1 == LVL_WIN) begin
                            state_d = WIN;
                        end
                    end else begin
                        hits_d = hits_q + HW'(1);
                    end
                end else if (press) begin
                    hits_d = '0;
                    if (misses_q == MISS_LAST) begin
                        misses_d = '0;
                        // Level 1 is the floor: the miss streak resets silently.
                        if (lvl_q > 3'd1) begin
                            lvl_d = lvl_q - 3'd1;
                            dn_d  = 1'b1;
                        end
                    end else begin
                        misses_d = misses_q + MW'(1);
                    end
                end
            end
            WIN: begin
                lvl_d = LVL_WIN;
                if (press) begin
                    state_d  = IDLE;
                    lvl_d    = 3'd0;
                    hits_d   = '0;
                    misses_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                lvl_d    = 3'd0;
                hits_d   = '0;
                misses_d = '0;
            end
        endcase
    end

    always_comb begin
        Lvl   = lvl_q;
        LvlUp = up_q;
        LvlDn = dn_q;
    end

endmodule

// File: tb/tb_level_tracker.sv
// Directed bench for level_tracker with a short debounce window (DEB_CYCLES=4).
module tb_level_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn = 1'b0;
    logic       Tgt = 1'b0;
    logic [2:0] Lvl;
    logic       LvlUp;
    logic       LvlDn;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    level_tracker #(
        .DEB_CYCLES  (4),
        .DEB_W       (16),
        .HITS_PER_LVL(3),
        .MISS_LIMIT  (2),
        .MAX_LVL     (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .Tgt  (Tgt),
        .Lvl  (Lvl),
        .LvlUp(LvlUp),
        .LvlDn(LvlDn)
    );

    // One clean debounced press; reports Lvl before/after the consuming edge (7)
    // and the pulse outputs on that edge and the following one.
    task automatic do_press(input logic tgt, output logic [2:0] pre, output logic [2:0] post,
                            output logic up, output logic dn, output logic up_n, output logic dn_n);
        @(negedge clk);
        btn = 1'b1;
        Tgt = tgt;
        repeat (6) @(posedge clk);
        #1 pre = Lvl;
        @(posedge clk);
        #1 post = Lvl; up = LvlUp; dn = LvlDn;
        @(posedge clk);
        #1 up_n = LvlUp; dn_n = LvlDn;
        @(negedge clk);
        btn = 1'b0;
        Tgt = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (Lvl !== 3'd0) $display("FAIL reset_lvl: got %0d expected 0", Lvl); else passed++;
        checks++; if (LvlUp !== 1'b0) $display("FAIL reset_up: got %0b expected 0", LvlUp); else passed++;
        checks++; if (LvlDn !== 1'b0) $display("FAIL reset_dn: got %0b expected 0", LvlDn); else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: Lvl=%0d LvlUp=%0b LvlDn=%0b", Lvl, LvlUp, LvlDn);
    endtask

    task automatic test_bounce();
        logic [6:0] pat = 7'b1110111;
        int nz = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            btn = pat[6-i];
            @(posedge clk);
            #1 if (Lvl !== 3'd0 || LvlUp !== 1'b0) nz++;
        end
        @(negedge clk);
        btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (Lvl !== 3'd0 || LvlUp !== 1'b0) nz++;
        end
        checks++; if (nz !== 0) $display("FAIL bounce_reject: %0d cycles with activity, expected 0", nz); else passed++;
        $display("bounce: Lvl=%0d active_cycles=%0d", Lvl, nz);
    endtask

    task automatic test_clean_press();
        int nz = 0;
        int chg = 0;
        @(negedge clk);
        btn = 1'b1;
        Tgt = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1 if (Lvl !== 3'd0) nz++;
        end
        checks++; if (nz !== 0) $display("FAIL early_lvl: %0d early edges nonzero, expected 0", nz); else passed++;
        @(posedge clk);
        #1;
        checks++; if (Lvl !== 3'd1) $display("FAIL start_lvl: got %0d expected 1", Lvl); else passed++;
        checks++; if (LvlUp !== 1'b0) $display("FAIL start_up: got %0b expected 0", LvlUp); else passed++;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 if (Lvl !== 3'd1 || LvlUp !== 1'b0 || LvlDn !== 1'b0) chg++;
        end
        checks++; if (chg !== 0) $display("FAIL held_btn: %0d cycles changed, expected 0", chg); else passed++;
        @(negedge clk);
        btn = 1'b0;
        repeat (10) @(posedge clk);
        $display("clean_press: Lvl=%0d held_changes=%0d", Lvl, chg);
    endtask

    task automatic test_advance_win();
        logic [2:0] pre, post, exp_l;
        logic up, dn, up_n, dn_n, exp_up;
        for (int i = 1; i <= 12; i++) begin
            do_press(1'b1, pre, post, up, dn, up_n, dn_n);
            exp_l  = 3'(1 + i / 3);
            exp_up = (i % 3 == 0);
            checks++; if (post !== exp_l) $display("FAIL win_lvl[%0d]: got %0d expected %0d", i, post, exp_l); else passed++;
            checks++; if (up !== exp_up) $display("FAIL win_up[%0d]: got %0b expected %0b", i, up, exp_up); else passed++;
            checks++; if (up_n !== 1'b0) $display("FAIL win_up_len[%0d]: got %0b expected 0", i, up_n); else passed++;
            checks++; if (dn !== 1'b0) $display("FAIL win_dn[%0d]: got %0b expected 0", i, dn); else passed++;
            $display("advance press %0d: Lvl %0d->%0d LvlUp=%0b", i, pre, post, up);
        end
        do_press(1'b1, pre, post, up, dn, up_n, dn_n);
        checks++; if (post !== 3'd0) $display("FAIL win_exit_lvl: got %0d expected 0", post); else passed++;
        checks++; if (up !== 1'b0 || dn !== 1'b0) $display("FAIL win_exit_pulse: got up=%0b dn=%0b expected 0 0", up, dn); else passed++;
        $display("win exit press: Lvl %0d->%0d", pre, post);
    endtask

    task automatic test_miss();
        logic [2:0] pre, post, exp_l;
        logic up, dn, up_n, dn_n;
        int   miss_lvl[6] = '{3, 2, 2, 1, 1, 1};
        logic miss_dn[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_press(1'b0, pre, post, up, dn, up_n, dn_n);
        checks++; if (post !== 3'd1) $display("FAIL miss_start: got %0d expected 1", post); else passed++;
        for (int j = 1; j <= 8; j++) begin
            do_press(1'b1, pre, post, up, dn, up_n, dn_n);
            exp_l = 3'(1 + j / 3);
            checks++; if (post !== exp_l) $display("FAIL miss_climb[%0d]: got %0d expected %0d", j, post, exp_l); else passed++;
            $display("climb hit %0d: Lvl %0d->%0d LvlUp=%0b", j, pre, post, up);
        end
        for (int k = 0; k < 6; k++) begin
            do_press(1'b0, pre, post, up, dn, up_n, dn_n);
            checks++; if (post !== 3'(miss_lvl[k])) $display("FAIL miss_lvl[%0d]: got %0d expected %0d", k, post, miss_lvl[k]); else passed++;
            checks++; if (dn !== miss_dn[k]) $display("FAIL miss_dn[%0d]: got %0b expected %0b", k, dn, miss_dn[k]); else passed++;
            checks++; if (dn_n !== 1'b0 || up !== 1'b0) $display("FAIL miss_pulse[%0d]: got dn_next=%0b up=%0b expected 0 0", k, dn_n, up); else passed++;
            $display("miss %0d: Lvl %0d->%0d LvlDn=%0b", k, pre, post, dn);
        end
    endtask

    task automatic test_interleave();
        logic [2:0] pre, post;
        logic up, dn, up_n, dn_n;
        logic seq_tgt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int   seq_lvl[7] = '{2, 2, 2, 2, 2, 2, 3};
        logic seq_up[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int j = 0; j < 3; j++) do_press(1'b1, pre, post, up, dn, up_n, dn_n);
        checks++; if (post !== 3'd2) $display("FAIL ilv_setup: got %0d expected 2", post); else passed++;
        for (int k = 0; k < 7; k++) begin
            do_press(seq_tgt[k], pre, post, up, dn, up_n, dn_n);
            checks++; if (post !== 3'(seq_lvl[k])) $display("FAIL ilv_lvl[%0d]: got %0d expected %0d", k, post, seq_lvl[k]); else passed++;
            checks++; if (up !== seq_up[k] || dn !== 1'b0) $display("FAIL ilv_pulse[%0d]: got up=%0b dn=%0b expected %0b 0", k, up, dn, seq_up[k]); else passed++;
            $display("interleave %0d tgt=%0b: Lvl %0d->%0d", k, seq_tgt[k], pre, post);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] pre, post;
        logic up, dn, up_n, dn_n;
        int nz = 0;
        for (int j = 0; j < 3; j++) do_press(1'b1, pre, post, up, dn, up_n, dn_n);
        checks++; if (post !== 3'd4) $display("FAIL ar_setup: got %0d expected 4", post); else passed++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        btn = 1'b1;
        #1;
        checks++; if (Lvl !== 3'd0) $display("FAIL ar_clear: got %0d expected 0", Lvl); else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1 if (Lvl !== 3'd0) nz++;
        end
        checks++; if (nz !== 0) $display("FAIL ar_early: %0d early edges nonzero, expected 0", nz); else passed++;
        @(posedge clk);
        #1;
        checks++; if (Lvl !== 3'd1) $display("FAIL ar_restart: got %0d expected 1", Lvl); else passed++;
        checks++; if (LvlUp !== 1'b0) $display("FAIL ar_restart_up: got %0b expected 0", LvlUp); else passed++;
        $display("async reset: restarted Lvl=%0d", Lvl);
        @(negedge clk);
        btn = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_advance_win();
        test_miss();
        test_interleave();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
